// File: rtl/e1ofn_pkg.sv
// Shared definitions for e1ofN (N=2) dual-rail control channels.
// Includes the token width, rail encode/decode helpers and the arbiter state type.
package e1ofn_pkg;

  localparam int M      = 3;
  localparam int NUM_IN = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Bit i uses the rail pair {d[2i+1] (true), d[2i] (false)}.
  function automatic logic [2*M-1:0] dr_encode(input logic [M-1:0] b);
    logic [2*M-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      r[2*i+1] = b[i];
      r[2*i]   = ~b[i];
    end
    return r;
  endfunction

  function automatic logic [M-1:0] dr_decode(input logic [2*M-1:0] d);
    logic [M-1:0] b;
    b = '0;
    for (int i = 0; i < M; i++) begin
      b[i] = d[2*i+1];
    end
    return b;
  endfunction

  function automatic logic is_valid(input logic [2*M-1:0] d);
    logic v;
    v = 1'b1;
    for (int i = 0; i < M; i++) begin
      v = v & (d[2*i] ^ d[2*i+1]);
    end
    return v;
  endfunction

  function automatic logic is_neutral(input logic [2*M-1:0] d);
    return (d == '0);
  endfunction

endpackage

// File: rtl/dr_completion_det.sv
// Completion detector for a 2M-rail dual-rail bus: flags a complete token or an all-low spacer.
module dr_completion_det #(
  parameter int M = 3
) (
  input  logic [2*M-1:0] i_d,
  output logic           o_valid,
  output logic           o_neutral
);

  // A token is complete only when every rail pair has exactly one rail high.
  always_comb begin
    o_valid = 1'b1;
    for (int i = 0; i < M; i++) begin
      o_valid = o_valid & (i_d[2*i] ^ i_d[2*i+1]);
    end
  end

  assign o_neutral = ~|i_d;

endmodule

// File: rtl/input_arbiter_4_3bit.sv
// Four-input round-robin arbiter for dual-rail control tokens; emits the winning input index
// as a dual-rail token and runs the 4-phase enable handshake on both sides.
module input_arbiter_4_3bit
  import e1ofn_pkg::*;
(
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [2*M-1:0] in1_d,
  output logic           in1_e,
  input  logic [2*M-1:0] in2_d,
  output logic           in2_e,
  input  logic [2*M-1:0] in3_d,
  output logic           in3_e,
  input  logic [2*M-1:0] in4_d,
  output logic           in4_e,
  output logic [2*M-1:0] out_d,
  input  logic           out_e
);

  logic [2*M-1:0]    w_in_d [NUM_IN];
  logic [NUM_IN-1:0] w_valid;
  logic [NUM_IN-1:0] w_neutral;

  arb_state_t        r_state, w_state_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [1:0]        r_winner, w_winner_nxt;
  logic [NUM_IN-1:0] r_in_e, w_in_e_nxt;
  logic [2*M-1:0]    r_out_d, w_out_d_nxt;

  logic              w_req_found;
  logic [1:0]        w_req_idx;

  assign w_in_d[0] = in1_d;
  assign w_in_d[1] = in2_d;
  assign w_in_d[2] = in3_d;
  assign w_in_d[3] = in4_d;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_det
    dr_completion_det #(.M(M)) u_det (
      .i_d      (w_in_d[g]),
      .o_valid  (w_valid[g]),
      .o_neutral(w_neutral[g])
    );
  end

  // First valid input at or after the pointer, scanning cyclically.
  always_comb begin
    w_req_found = 1'b0;
    w_req_idx   = r_ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      logic [1:0] cand;
      cand = r_ptr + 2'(k);
      if (!w_req_found && w_valid[cand]) begin
        w_req_found = 1'b1;
        w_req_idx   = cand;
      end
    end
  end

  // All enables high only happens once we are settled in IDLE; the first edge after reset
  // just raises the enables, so no grant can slip out before the inputs see ready.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_winner_nxt = r_winner;
    w_in_e_nxt   = r_in_e;
    w_out_d_nxt  = r_out_d;
    unique case (r_state)
      IDLE: begin
        w_in_e_nxt  = '1;
        w_out_d_nxt = '0;
        if ((&r_in_e) && out_e && w_req_found) begin
          w_in_e_nxt[w_req_idx] = 1'b0;
          w_out_d_nxt           = dr_encode(M'(w_req_idx));
          w_winner_nxt          = w_req_idx;
          w_state_nxt           = SEND;
        end
      end
      SEND: begin
        if (!out_e) begin
          w_out_d_nxt = '0;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (out_e && w_neutral[r_winner]) begin
          w_in_e_nxt[r_winner] = 1'b1;
          w_ptr_nxt            = r_winner + 2'd1;
          w_state_nxt          = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_state  <= IDLE;
      r_ptr    <= 2'd0;
      r_winner <= 2'd0;
      r_in_e   <= '0;
      r_out_d  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_winner <= w_winner_nxt;
      r_in_e   <= w_in_e_nxt;
      r_out_d  <= w_out_d_nxt;
    end
  end

  assign in1_e = r_in_e[0];
  assign in2_e = r_in_e[1];
  assign in3_e = r_in_e[2];
  assign in4_e = r_in_e[3];
  assign out_d = r_out_d;

endmodule

// File: tb/tb_input_arbiter_4_3bit.sv
// Directed bench for input_arbiter_4_3bit: reset, single grant, round-robin order,
// fairness, backpressure and rejection of malformed tokens.
module tb_input_arbiter_4_3bit;

  logic       clk;
  logic       resetN;
  logic [5:0] inD [4];
  logic       in1E, in2E, in3E, in4E;
  logic [5:0] outD;
  logic       outE;

  int testCount = 0;
  int failCount = 0;

  // Dual-rail tokens for indices 0..3 (bit i: false rail d[2i], true rail d[2i+1]).
  logic [5:0] tokTab [4] = '{6'b010101, 6'b010110, 6'b011001, 6'b011010};

  input_arbiter_4_3bit dut (
    .CLK   (clk),
    ._RESET(resetN),
    .in1_d (inD[0]),
    .in1_e (in1E),
    .in2_d (inD[1]),
    .in2_e (in2E),
    .in3_d (inD[2]),
    .in3_e (in3E),
    .in4_d (inD[3]),
    .in4_e (in4E),
    .out_d (outD),
    .out_e (outE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] d1, input logic [5:0] d2,
                               input logic [5:0] d3, input logic [5:0] d4, input logic oe);
    inD[0] = d1;
    inD[1] = d2;
    inD[2] = d3;
    inD[3] = d4;
    outE   = oe;
  endtask

  // Expected vector is {in4_e, in3_e, in2_e, in1_e, out_d}.
  task automatic checkOutput(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = {in4E, in3E, in2E, in1E, outD};
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Expects a grant to input k on the next edge, then completes the handshake.
  task automatic doGrant(input int k, input string tag);
    logic [3:0] mask;
    mask = 4'b1111 & ~(4'b0001 << k);
    cyc();
    checkOutput({tag, "_grant"}, {mask, tokTab[k]});
    outE = 1'b0;
    cyc();
    checkOutput({tag, "_ack"}, {mask, 6'b000000});
    inD[k] = 6'b000000;
    outE   = 1'b1;
    cyc();
    checkOutput({tag, "_release"}, {4'b1111, 6'b000000});
  endtask

  task automatic doReset();
    resetN = 1'b0;
    #1;
    checkOutput("async_reset", 10'b0);
    cyc();
    applyStimulus(6'b0, 6'b0, 6'b0, 6'b0, 1'b1);
    resetN = 1'b1;
    cyc();
    checkOutput("post_reset_ready", {4'b1111, 6'b000000});
  endtask

  initial begin
    // Reset held with tokens present
    resetN = 1'b0;
    applyStimulus(tokTab[0], tokTab[1], tokTab[2], tokTab[3], 1'b1);
    cyc();
    checkOutput("reset_hold_a", 10'b0);
    cyc();
    checkOutput("reset_hold_b", 10'b0);
    resetN = 1'b1;
    cyc();
    checkOutput("reset_release_ready", {4'b1111, 6'b000000});
    applyStimulus(6'b0, 6'b0, 6'b0, 6'b0, 1'b1);
    cyc();
    checkOutput("idle_no_request", {4'b1111, 6'b000000});

    // Single request on input 2
    applyStimulus(6'b0, 6'b010110, 6'b0, 6'b0, 1'b1);
    cyc();
    checkOutput("single_grant", {4'b1101, 6'b010110});
    cyc();
    checkOutput("single_hold", {4'b1101, 6'b010110});
    outE = 1'b0;
    cyc();
    checkOutput("single_neutral", {4'b1101, 6'b000000});
    cyc();
    checkOutput("single_wait", {4'b1101, 6'b000000});
    applyStimulus(6'b0, 6'b0, 6'b0, 6'b0, 1'b1);
    cyc();
    checkOutput("single_release", {4'b1111, 6'b000000});
    cyc();
    checkOutput("single_idle", {4'b1111, 6'b000000});

    // All four requesting: order 0,1,2,3,0
    doReset();
    applyStimulus(tokTab[2], tokTab[0], tokTab[3], tokTab[1], 1'b1);
    for (int i = 0; i < 5; i++) begin
      doGrant(i % 4, "simul");
      inD[i % 4] = tokTab[(i + 1) % 4];
    end

    // Inputs 1 and 4 requesting continuously: 0,3,0,3
    doReset();
    applyStimulus(tokTab[1], 6'b0, 6'b0, tokTab[2], 1'b1);
    doGrant(0, "fair0");
    inD[0] = tokTab[3];
    doGrant(3, "fair3");
    inD[3] = tokTab[0];
    doGrant(0, "fair0b");
    inD[0] = tokTab[2];
    doGrant(3, "fair3b");

    // Backpressure with input 3 valid
    applyStimulus(6'b0, 6'b0, tokTab[1], 6'b0, 1'b0);
    cyc();
    checkOutput("bp_hold_a", {4'b1111, 6'b000000});
    cyc();
    checkOutput("bp_hold_b", {4'b1111, 6'b000000});
    outE = 1'b1;
    doGrant(2, "bp");

    // Malformed tokens on input 1 are never granted
    applyStimulus(6'b000011, 6'b0, 6'b0, 6'b0, 1'b1);
    cyc();
    checkOutput("illegal_a", {4'b1111, 6'b000000});
    cyc();
    checkOutput("illegal_b", {4'b1111, 6'b000000});
    inD[0] = 6'b000001;
    cyc();
    checkOutput("partial_a", {4'b1111, 6'b000000});
    inD[0] = 6'b111111;
    cyc();
    checkOutput("all_rails", {4'b1111, 6'b000000});
    inD[0] = 6'b010101;
    doGrant(0, "corrected");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
